// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial WIDTH-bit add/subtract unit with start/done handshake and registered flags
//   clk, rst (async, active-high)
//   start, A, B, mode (1 = subtract, B inverted), Co (carry-in) : request and operands, latched on accept
//   busy, done (one-cycle pulse) : handshake
//   S, cf, zf, of, pf, sf : registered result and flags, updated only on completion
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    input  logic             Co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cf,
    output logic             zf,
    output logic             of,
    output logic             pf,
    output logic             sf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and DIGIT >= 1 dividing WIDTH");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
    logic             carry_q, carry_d, done_q, done_d;
    logic             cf_q, cf_d, zf_q, zf_d, of_q, of_d, pf_q, pf_d, sf_q, sf_d;
    logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
    logic [WIDTH-1:0] full;
    logic             dig_co, msb_ci, last;

    always_comb begin
        a_dig = a_q[int'(cnt_q)*DIGIT +: DIGIT];
        b_dig = b_q[int'(cnt_q)*DIGIT +: DIGIT];
        {dig_co, sum_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        // carry into the top bit of the digit recovered from its sum bit
        msb_ci = sum_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
        full = sum_q;
        full[int'(cnt_q)*DIGIT +: DIGIT] = sum_dig;
        last = cnt_q == CW'(N - 1);
        state_d = state_q;
        cnt_d = cnt_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        carry_d = carry_q;
        s_d = s_q;
        cf_d = cf_q;
        zf_d = zf_q;
        of_d = of_q;
        pf_d = pf_q;
        sf_d = sf_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                a_d = A;
                b_d = B ^ {WIDTH{mode}};
                carry_d = Co;
                cnt_d = '0;
                sum_d = '0;
                state_d = RUN;
            end
        end else begin
            sum_d = full;
            carry_d = dig_co;
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (last) begin
                state_d = IDLE;
                done_d = 1'b1;
                s_d = full;
                cf_d = dig_co;
                zf_d = ~|full;
                of_d = dig_co ^ msb_ci;
                pf_d = ^full;
                sf_d = full[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            s_q <= '0;
            cf_q <= 1'b0;
            zf_q <= 1'b0;
            of_q <= 1'b0;
            pf_q <= 1'b0;
            sf_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            carry_q <= carry_d;
            s_q <= s_d;
            cf_q <= cf_d;
            zf_q <= zf_d;
            of_q <= of_d;
            pf_q <= pf_d;
            sf_q <= sf_d;
            done_q <= done_d;
        end
    end

    assign busy = state_q == RUN;
    assign done = done_q;
    assign S    = s_q;
    assign cf   = cf_q;
    assign zf   = zf_q;
    assign of   = of_q;
    assign pf   = pf_q;
    assign sf   = sf_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: scoreboard bench for addsub_serial with DIGIT = 4, 16 and 1 driven in parallel
module tb_addsub_serial;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, Co = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        busy_w [3], done_w [3], cf_w [3], zf_w [3], of_w [3], pf_w [3], sf_w [3];
    logic [15:0] s_w [3];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b, input logic m, input logic c);
        logic [15:0] bx;
        logic [16:0] r;
        logic        cm;
        bx = b ^ {16{m}};
        r  = {1'b0, a} + {1'b0, bx} + {16'd0, c};
        cm = r[15] ^ a[15] ^ bx[15];
        return {r[16], r[15:0] == 16'd0, r[16] ^ cm, ^r[15:0], r[15], r[15:0]};
    endfunction

    function automatic logic [20:0] out_vec(input int i);
        return {cf_w[i], zf_w[i], of_w[i], pf_w[i], sf_w[i], s_w[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 16 : 1;
        localparam int NN = 16 / DG;
        logic [20:0] sb [$];
        logic [20:0] last = '0;
        int          mcnt = 0;
        logic        mdone = 1'b0;

        addsub_serial #(.WIDTH(16), .DIGIT(DG)) u_dut (
            .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .mode(mode), .Co(Co),
            .busy(busy_w[g]), .done(done_w[g]), .S(s_w[g]),
            .cf(cf_w[g]), .zf(zf_w[g]), .of(of_w[g]), .pf(pf_w[g]), .sf(sf_w[g])
        );

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mcnt <= 0;
                mdone <= 1'b0;
                sb.delete();
            end else begin
                mdone <= (mcnt == 1);
                if (mcnt == 0 && start) begin
                    sb.push_back(model(A, B, mode, Co));
                    mcnt <= NN;
                end else if (mcnt != 0) begin
                    mcnt <= mcnt - 1;
                end
            end
        end

        always @(negedge clk) begin
            if (rst) last = '0;
            else if (done_w[g]) begin
                if (sb.size() == 0) check($sformatf("sb_empty%0d", g), 32'd1, 32'd0);
                else last = sb.pop_front();
            end
            check($sformatf("out%0d", g), 32'(out_vec(g)), 32'(last));
            check($sformatf("busy%0d", g), 32'(busy_w[g]), 32'(mcnt != 0));
            check($sformatf("done%0d", g), 32'(done_w[g]), 32'(mdone));
            check($sformatf("busy_done%0d", g), 32'(busy_w[g] & done_w[g]), 32'd0);
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m, input logic c);
        @(negedge clk);
        A = a; B = b; mode = m; Co = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); mode = 1'($urandom); Co = 1'($urandom);
        repeat (18) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [20:0] exp);
        for (int i = 0; i < 3; i++) check($sformatf("%s_%0d", tag, i), 32'(out_vec(i)), 32'(exp));
    endtask

    initial begin
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_out", 32'(out_vec(i)), 32'd0);
            check("rst_busy", 32'(busy_w[i]), 32'd0);
            check("rst_done", 32'(done_w[i]), 32'd0);
        end
        @(negedge clk);
        #2 rst = 1'b0;

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        check_all("add", {5'b00000, 16'h2233});
        run_op(16'h0005, 16'h0005, 1'b1, 1'b1);
        check_all("sub_eq", {5'b11000, 16'h0000});
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check_all("ovf", {5'b00111, 16'h8000});
        run_op(16'h0000, 16'h0001, 1'b1, 1'b1);
        check_all("borrow", {5'b00001, 16'hFFFF});

        @(negedge clk);
        A = 16'h1234; B = 16'h0FFF; mode = 1'b0; Co = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'hAAAA; B = 16'h1111; mode = 1'b1; Co = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        check("ignored_0", 32'(out_vec(0)), 32'({5'b00000, 16'h2233}));
        check("ignored_2", 32'(out_vec(2)), 32'({5'b00000, 16'h2233}));

        @(negedge clk);
        A = 16'h1234; B = 16'h0FFF; mode = 1'b0; Co = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        @(negedge clk);
        A = 16'h1234; B = 16'h0FFF; mode = 1'b0; Co = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("abort_out", 32'(out_vec(i)), 32'd0);
            check("abort_busy", 32'(busy_w[i]), 32'd0);
            check("abort_done", 32'(done_w[i]), 32'd0);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        check_all("after_rst", {5'b00000, 16'h1010});

        for (int k = 0; k < 1000; k++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
